// File: rtl/rs422_uart_rx.sv
// rs422_uart_rx: receiver for one RS422 loopback line. Recovers 8N1 frames
// from the asynchronous RX input. Completed bytes are offered on a STB/ACK
// stream. Framing errors and dropped bytes are reported as one-cycle pulses.
module rs422_uart_rx #(
   parameter int BAUD_RATE       = 115200,
   parameter int CLOCK_FREQUENCY = 100000000
) (
   input  logic       OPB_CLK,
   input  logic       OPB_RST,
   input  logic       RX,
   output logic [7:0] DATA_STREAM_OUT,
   output logic       DATA_STREAM_OUT_STB,
   input  logic       DATA_STREAM_OUT_ACK,
   output logic       FRAME_ERR,
   output logic       OVERRUN,
   output logic       BUSY
);

   localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int TW           = $clog2(CLKS_PER_BIT) + 1;

   localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);
   localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);

   // Fewer than 4 clocks per bit leaves no usable mid-bit sample point.
   if (CLKS_PER_BIT < 4) begin : g_bad_ratio
      $error("rs422_uart_rx: CLKS_PER_BIT must be at least 4");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          stb_q, stb_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          busy_q, busy_d;
   logic          byte_done_s;
   logic          rxs_s;

   assign rxs_s = sync2_q;

   // Frame FSM: start validation, mid-bit data sampling, stop check, break wait.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q + TW'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      byte_done_s = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (!rxs_s) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (timer_q == HALF_END) begin
               timer_d   = '0;
               bit_idx_d = 3'd0;
               // A line that is high again at mid start bit was only a glitch.
               if (!rxs_s) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (timer_q == BIT_END) begin
               timer_d = '0;
               shift_d = {rxs_s, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  state_d   = ST_DATA;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (timer_q == BIT_END) begin
               timer_d = '0;
               // Returning to IDLE at the stop mid-sample allows zero-gap frames.
               if (rxs_s) begin
                  byte_done_s = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BRK;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_BRK: begin
            timer_d = '0;
            if (rxs_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BRK;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Output stream: load on completion, hold until ACK, drop on overrun.
   always_comb begin
      data_d    = data_q;
      stb_d     = stb_q & ~DATA_STREAM_OUT_ACK;
      overrun_d = 1'b0;
      busy_d    = (state_d != ST_IDLE);
      if (byte_done_s) begin
         // A byte accepted in this same cycle frees the holding register.
         if (!stb_q || DATA_STREAM_OUT_ACK) begin
            data_d = shift_d;
            stb_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else begin
         data_d = data_q;
      end
   end

   // State and output registers; synchronizer resets to idle-high.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         stb_q       <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= RX;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         stb_q       <= stb_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign DATA_STREAM_OUT     = data_q;
   assign DATA_STREAM_OUT_STB = stb_q;
   assign FRAME_ERR           = frame_err_q;
   assign OVERRUN             = overrun_q;
   assign BUSY                = busy_q;

endmodule

// File: doc/rs422_uart_rx.md
Name: rs422_uart_rx

Overview:
- Standalone RS422 UART receiver.
- One instance per monitored RS422 input line (9 lines) in the RS422 loopback test block.
- Converts the asynchronous serial line into a byte stream with a STB/ACK handshake.
- Downstream logic uses the stream to count received bytes and compare each byte against the test pattern.
- Also flags framing errors and overruns, so the test block can separate line faults from pattern mismatches.

Parameters:
- BAUD_RATE, 115200: serial bit rate in bit/s.
- CLOCK_FREQUENCY, 100000000: OPB_CLK frequency in Hz.
- CLKS_PER_BIT (derived, not overridable): CLOCK_FREQUENCY / BAUD_RATE, integer truncation. Elaboration fails if CLKS_PER_BIT < 4.
- HALF_BIT (derived): CLKS_PER_BIT / 2, truncated.

Ports:
- OPB_CLK  in  1  system clock.
- OPB_RST  in  1  reset.
- RX  in  1  raw serial input, asynchronous to OPB_CLK, idle high.
- DATA_STREAM_OUT  out  8  received byte, valid while DATA_STREAM_OUT_STB=1.
- DATA_STREAM_OUT_STB  out  1  byte-available strobe, held until accepted.
- DATA_STREAM_OUT_ACK  in  1  consumer accepts; a transfer occurs on any cycle with STB=1 and ACK=1.
- FRAME_ERR  out  1  one-cycle pulse when the stop bit is sampled low.
- OVERRUN  out  1  one-cycle pulse when a completed byte is dropped.
- BUSY  out  1  high in every state except IDLE.

Interface decision: reset OPB_RST, asynchronous, active-high; clock OPB_CLK.

Behaviour:
- Synchronizer:
  - RX passes through a 2-flop synchronizer; both flops reset to 1, so releasing reset never produces a false start.
  - All logic below uses only the synchronized value rxs.
- Bit timer: counter of width clog2(CLKS_PER_BIT)+1, cleared on every state entry.
- FSM states and transitions:
  - IDLE: rxs=0 -> START.
  - START: timer counts to HALF_BIT-1. Sample rxs there: 0 -> DATA (bit index 0); 1 -> IDLE (glitch rejected, nothing reported).
  - DATA: sample rxs every CLKS_PER_BIT cycles after the start mid-sample. Bits shift into the shift register LSB first. After bit 7 -> STOP.
  - STOP: sample CLKS_PER_BIT cycles after the bit-7 sample.
    - rxs=1: byte complete -> IDLE.
    - rxs=0: FRAME_ERR pulse, byte discarded -> BREAK.
  - BREAK: wait until rxs=1 -> IDLE. A held-low line produces exactly one FRAME_ERR and no bytes.
- Output handshake:
  - On byte complete with STB=0: DATA_STREAM_OUT <= byte, STB <= 1 on the next cycle. Latency is 1 cycle after the stop-bit sample.
  - STB stays 1 and DATA_STREAM_OUT stays stable until a cycle with ACK=1; STB is 0 the following cycle.
  - ACK while STB=0 is ignored.
  - Byte complete while STB=1 and ACK=0: the new byte is dropped, the held byte is kept, and OVERRUN pulses for 1 cycle.
  - Byte complete on the same cycle as an accepting ACK: the new byte is loaded, STB stays 1, no OVERRUN.
  - With ACK tied to STB (as the test block does), STB is a single-cycle pulse per byte.
- Back-to-back frames: IDLE is re-entered at the stop mid-sample, so a start bit arriving directly after the stop bit is detected. No idle gap is required.
- Reset values: DATA_STREAM_OUT=0, STB=0, FRAME_ERR=0, OVERRUN=0, BUSY=0, FSM=IDLE, timer=0, shift register=0.
- Reset mid-frame: the partial byte is lost and no pulses are generated. After reset release, the first falling edge on rxs starts a new frame.
- Sampling point: each bit is sampled at its nominal centre ±1 cycle, plus the synchronizer delay of 2 cycles.

Test Plan:
All tests use CLOCK_FREQUENCY=1600000 and BAUD_RATE=100000, so CLKS_PER_BIT=16.
1. Single byte: send 0xA5 (start, LSB first, 1 stop), ACK=0.
   -> DATA_STREAM_OUT=0xA5, STB rises 152–156 cycles after the RX falling edge and stays high.
   -> Assert ACK for 1 cycle -> STB=0 on the next cycle.
2. Back-to-back stream: send 0x00, 0xFF, 0x55, 0x3C with no idle gap, ACK tied to STB.
   -> Exactly 4 single-cycle STB pulses with those values, in that order.
   -> FRAME_ERR=0 and OVERRUN=0 throughout.
3. Glitch and break:
   - 5-cycle low pulse on RX -> FSM returns to IDLE; no STB, no FRAME_ERR; BUSY high for at most HALF_BIT+3 cycles.
   - Then hold RX low for 40 bit times -> exactly one FRAME_ERR pulse, no STB.
   - Release RX, then send 0x81 -> 0x81 received.
4. Overrun: send 0x11 then 0x22, ACK=0.
   -> OVERRUN pulses once, ~160 cycles after the first STB.
   -> DATA_STREAM_OUT stays 0x11.
   -> ACK -> STB falls, and no 0x22 is delivered.
5. Simultaneous accept: time ACK to coincide with completion of the second byte.
   -> STB stays 1, DATA_STREAM_OUT becomes the second byte, OVERRUN=0.
6. Reset mid-frame: assert OPB_RST during bit 4 of 0x5A.
   -> All outputs go to 0 immediately, with no STB after release.
   -> The next frame 0xC3 is received correctly.
